// File: rtl/rp_trigger_pkg.sv
// Shared FSM state encoding and clamp limits for reference_pulse_generator.
package rp_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_DELAY = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } rp_state_e;

  localparam int unsigned RP_MIN_PERIOD = 2;
  localparam int unsigned RP_MIN_HIGH   = 1;

endpackage

// File: rtl/reference_pulse_generator_if.sv
// Control/status bundle of reference_pulse_generator.
// PULSE_BURST_EN adds burst_count and done.
interface reference_pulse_generator_if #(
  parameter int COUNTER_WIDTH = 32,
  parameter int BURST_WIDTH   = 16
);

  logic                     enable;
  logic                     arm;
  logic                     stop;
  logic [COUNTER_WIDTH-1:0] period;
  logic [COUNTER_WIDTH-1:0] high_samples;
  logic [COUNTER_WIDTH-1:0] start_delay;
  logic                     pulse_out;
  logic                     period_tick;
  logic                     running;
  logic [COUNTER_WIDTH-1:0] periods_done;
`ifdef PULSE_BURST_EN
  logic [BURST_WIDTH-1:0]   burst_count;
  logic                     done;

  modport master (
    output enable, arm, stop, period, high_samples, start_delay, burst_count,
    input  pulse_out, period_tick, running, periods_done, done
  );
  modport slave (
    input  enable, arm, stop, period, high_samples, start_delay, burst_count,
    output pulse_out, period_tick, running, periods_done, done
  );
`else
  modport master (
    output enable, arm, stop, period, high_samples, start_delay,
    input  pulse_out, period_tick, running, periods_done
  );
  modport slave (
    input  enable, arm, stop, period, high_samples, start_delay,
    output pulse_out, period_tick, running, periods_done
  );
`endif

  if (COUNTER_WIDTH < 2 || BURST_WIDTH < 1) begin : g_bad_params
    $error("reference_pulse_generator_if: illegal width parameters");
  end

endinterface

// File: rtl/pulse_period_counter.sv
// Period counter: shadow latch of period/high with clamping, sample counter,
// registered pulse level and last-sample tick.
module pulse_period_counter
  import rp_trigger_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic                     run,
  input  logic [COUNTER_WIDTH-1:0] period_in,
  input  logic [COUNTER_WIDTH-1:0] high_in,
  output logic                     pulse_q,
  output logic                     tick_q,
  output logic                     tick_next
);

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;

  function automatic cnt_t clamp_period(input cnt_t p);
    return (p < cnt_t'(RP_MIN_PERIOD)) ? cnt_t'(RP_MIN_PERIOD) : p;
  endfunction

  // Keeps at least one rising and one falling edge in every period.
  function automatic cnt_t clamp_high(input cnt_t pc, input cnt_t h);
    if (h < cnt_t'(RP_MIN_HIGH)) return cnt_t'(RP_MIN_HIGH);
    if (h >= pc) return pc - cnt_t'(1);
    return h;
  endfunction

  cnt_t cnt_q, cnt_d;
  cnt_t per_q, per_d;
  cnt_t high_q, high_d;
  cnt_t per_in_c, high_in_c;
  cnt_t adv_cnt, adv_per, adv_high;
  logic wrap, tick_if_run;
  logic pulse_d, tick_d;

  always_comb begin
    per_in_c    = clamp_period(period_in);
    high_in_c   = clamp_high(per_in_c, high_in);
    wrap        = (cnt_q == per_q - cnt_t'(1));
    adv_cnt     = wrap ? '0 : cnt_q + cnt_t'(1);
    adv_per     = wrap ? per_in_c : per_q;
    adv_high    = wrap ? high_in_c : high_q;
    tick_if_run = (adv_cnt == adv_per - cnt_t'(1));

    cnt_d  = '0;
    per_d  = per_q;
    high_d = high_q;
    if (start) begin
      per_d  = per_in_c;
      high_d = high_in_c;
    end else if (run) begin
      cnt_d  = adv_cnt;
      per_d  = adv_per;
      high_d = adv_high;
    end
    pulse_d = (start || run) && (cnt_d < high_d);
    tick_d  = run && tick_if_run;
  end

  assign tick_next = tick_if_run;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q   <= '0;
      per_q   <= '0;
      high_q  <= '0;
      pulse_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      high_q  <= high_d;
      pulse_q <= pulse_d;
      tick_q  <= tick_d;
    end
  end

endmodule

// File: rtl/reference_pulse_generator.sv
// Reference pulse generator: arm/stop FSM around a clamped period counter.
// Define PULSE_BURST_EN for burst mode (burst_count input, done output).
module reference_pulse_generator
  import rp_trigger_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int BURST_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        aresetn,
  reference_pulse_generator_if.slave  bus
);

  if (COUNTER_WIDTH < 2 || BURST_WIDTH < 1) begin : g_bad_params
    $error("reference_pulse_generator: illegal width parameters");
  end

  rp_state_e                state_q, state_d;
  logic [COUNTER_WIDTH-1:0] dly_q, dly_d;
  logic [COUNTER_WIDTH-1:0] pd_q, pd_d;
  logic                     running_q, running_d;
  logic                     cnt_start, cnt_run;
  logic                     pulse, tick, tick_next;
`ifdef PULSE_BURST_EN
  logic [BURST_WIDTH-1:0]   burst_q, burst_d;
  logic                     done_q, done_d;
`endif

  function automatic logic is_active(input rp_state_e s);
    return (s == ST_WAIT_DELAY) || (s == ST_RUN);
  endfunction

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    pd_d      = pd_q;
    cnt_start = 1'b0;
    cnt_run   = 1'b0;
`ifdef PULSE_BURST_EN
    burst_d   = burst_q;
    done_d    = done_q;
`endif
    if (!bus.enable) begin
      state_d = ST_IDLE;
      dly_d   = '0;
      pd_d    = '0;
`ifdef PULSE_BURST_EN
      burst_d = '0;
      done_d  = 1'b0;
`endif
    end else if (bus.stop) begin
      state_d = ST_IDLE;
      dly_d   = '0;
`ifdef PULSE_BURST_EN
      done_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.arm) begin
            state_d = ST_WAIT_DELAY;
            dly_d   = bus.start_delay;
            pd_d    = '0;
`ifdef PULSE_BURST_EN
            burst_d = bus.burst_count;
            done_d  = 1'b0;
`endif
          end
        end
        // Delay of zero still spends one cycle here, so the first high
        // sample lands one edge after the arm edge.
        ST_WAIT_DELAY: begin
          if (dly_q == '0) begin
            state_d   = ST_RUN;
            cnt_start = 1'b1;
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
        ST_RUN: begin
          cnt_run = 1'b1;
          if (tick_next) begin
            pd_d = pd_q + 1'b1;
`ifdef PULSE_BURST_EN
            if (burst_q != '0 && pd_d == COUNTER_WIDTH'(burst_q)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    running_d = is_active(state_q) && is_active(state_d);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      dly_q     <= '0;
      pd_q      <= '0;
      running_q <= 1'b0;
`ifdef PULSE_BURST_EN
      burst_q   <= '0;
      done_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      pd_q      <= pd_d;
      running_q <= running_d;
`ifdef PULSE_BURST_EN
      burst_q   <= burst_d;
      done_q    <= done_d;
`endif
    end
  end

  pulse_period_counter #(
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_counter (
    .clk       (clk),
    .aresetn   (aresetn),
    .start     (cnt_start),
    .run       (cnt_run),
    .period_in (bus.period),
    .high_in   (bus.high_samples),
    .pulse_q   (pulse),
    .tick_q    (tick),
    .tick_next (tick_next)
  );

  assign bus.pulse_out    = pulse;
  assign bus.period_tick  = tick;
  assign bus.running      = running_q;
  assign bus.periods_done = pd_q;
`ifdef PULSE_BURST_EN
  assign bus.done         = done_q;
`endif

endmodule

// File: doc/reference_pulse_generator.md
REFERENCE_PULSE_GENERATOR -- requirements
Module: reference_pulse_generator

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32, width of period/high/delay counters.
REQ-002 SHALL have parameter BURST_WIDTH, default 16, width of burst period count.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port enable  input  1  block enable; low forces the IDLE state synchronously.
REQ-006 SHALL have port arm  input  1  single-cycle start request.
REQ-007 SHALL have port stop  input  1  single-cycle abort request.
REQ-008 SHALL have port period  input  COUNTER_WIDTH  samples per pulse period P.
REQ-009 SHALL have port high_samples  input  COUNTER_WIDTH  samples pulse_out is high per period H.
REQ-010 SHALL have port start_delay  input  COUNTER_WIDTH  samples between arm and first rising edge D.
REQ-011 SHALL have port pulse_out  output  1  registered reference pulse, suitable for driving a DIO pin.
REQ-012 SHALL have port period_tick  output  1  one-cycle strobe on the last sample of every period.
REQ-013 SHALL have port running  output  1  high in WAIT_DELAY and RUN.
REQ-014 SHALL have port periods_done  output  COUNTER_WIDTH  number of completed periods since the last arm.

Function
REQ-015 SHALL implement the states IDLE, WAIT_DELAY, RUN and DONE.
REQ-016 SHALL go IDLE->WAIT_DELAY on the edge that samples arm=1; in all other states arm SHALL be ignored except in DONE, where arm SHALL go to WAIT_DELAY.
REQ-017 SHALL go WAIT_DELAY->RUN after D cycles; the first pulse_out=1 SHALL appear at edge N+1+D, where N is the arm edge (D=0 gives edge N+1).
REQ-018 SHALL, in RUN, run counter cnt from 0 to P-1 and wrap, and SHALL register pulse_out = (cnt < H).
REQ-019 SHALL assert period_tick for exactly the cycle with cnt==P-1, and SHALL increment periods_done on that cycle; periods_done SHALL wrap at 2^COUNTER_WIDTH.
REQ-020 SHALL latch P and H into shadow registers on entry to RUN and at every wrap; input changes mid-period SHALL take effect at the next period only.
REQ-021 SHALL clamp latched values: P<2 becomes 2, H=0 becomes 1, H>=P becomes P-1, so every period contains at least one rising edge and one falling edge.
REQ-022 SHALL return to IDLE on stop=1 from any state, with pulse_out=0 on the next cycle; stop SHALL win over a simultaneous arm.
REQ-023 SHALL clear periods_done on every accepted arm.
REQ-024 SHALL, when enable=0, hold the IDLE state with all outputs 0 and counters cleared.

Reset
REQ-025 SHALL, while aresetn=0, asynchronously set state=IDLE, pulse_out=0, period_tick=0, running=0, periods_done=0 and clear all internal counters and shadow registers.
REQ-026 SHALL stay in IDLE after reset release until an arm is sampled.

Configuration
REQ-027 SHALL compile in burst mode only when PULSE_BURST_EN is defined; burst mode adds input burst_count (BURST_WIDTH) and output done (1).
REQ-028 SHALL, with PULSE_BURST_EN and burst_count=B>0 latched at arm, go RUN->DONE at the B-th period_tick, with pulse_out=0 and done=1 held until the next arm or stop; B=0 SHALL mean continuous operation.
REQ-029 SHALL, without PULSE_BURST_EN, omit burst_count and done and never enter DONE.

Structure
REQ-030 SHALL place the state encoding and clamp constants (minimum period 2, minimum high 1) in shared package rp_trigger_pkg.
REQ-031 SHALL split out sub-module pulse_period_counter (shadow latch, clamp, cnt, wrap/tick generation); the FSM stays in the top module.

Verification
REQ-032 Bench SHALL check: P=10, H=3, D=0, arm at edge 5 -> pulse_out high at edges 6-8, low at edges 9-15, period_tick at edge 15, periods_done=1.
REQ-033 Bench SHALL check: D=4, arm at edge 0 -> first rising edge at edge 5, with running=1 from edge 1.
REQ-034 Bench SHALL check clamping: P=1, H=0 -> 2-cycle period with 1 cycle high; P=8, H=8 -> 7 cycles high, 1 cycle low.
REQ-035 Bench SHALL check: P changed 10->20 mid-period -> current period stays 10 cycles and the next period is 20 cycles.
REQ-036 Bench SHALL check: arm and stop in the same cycle -> stays IDLE; aresetn low in mid-RUN -> pulse_out 0 immediately without waiting for a clock edge.
REQ-037 Bench SHALL check, with PULSE_BURST_EN, B=3, P=4 -> exactly 3 pulses, done=1 at the third tick, and a re-arm restarts with periods_done=0.
